// File: rtl/tlb_op_ctrl.sv
// CP0 TLB instruction sequencer (TLBP/TLBR/TLBWI/TLBWR) and owner of the CP0 Random counter.
// TLBP walks the array one entry per cycle through the single indexed read port.
module tlb_op_ctrl #(
  parameter int NUM_ENTRIES = 16,
  parameter int IDX_W       = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             op_valid_i,
  input  logic [1:0]       op_i,
  output logic             op_ready_o,
  output logic             done_o,
  input  logic [31:0]      cp0_entryhi_i,
  input  logic [31:0]      cp0_entrylo0_i,
  input  logic [31:0]      cp0_entrylo1_i,
  input  logic [31:0]      cp0_index_i,
  input  logic [IDX_W-1:0] cp0_wired_i,
  input  logic             cp0_wired_wr_i,
  output logic [IDX_W-1:0] random_o,
  output logic             index_wr_o,
  output logic [31:0]      index_o,
  output logic             entry_wr_o,
  output logic [31:0]      entryhi_o,
  output logic [31:0]      entrylo0_o,
  output logic [31:0]      entrylo1_o,
  output logic             tlb_wr_o,
  output logic [IDX_W-1:0] tlb_index_o,
  output logic [31:0]      tlb_entryhi_o,
  output logic [31:0]      tlb_entrylo0_o,
  output logic [31:0]      tlb_entrylo1_o,
  output logic [IDX_W-1:0] tlb_rd_index_o,
  input  logic [31:0]      tlb_rd_entryhi_i,
  input  logic [31:0]      tlb_rd_entrylo0_i,
  input  logic [31:0]      tlb_rd_entrylo1_i
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PROBE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] OP_TLBP  = 2'b00;
  localparam logic [1:0] OP_TLBR  = 2'b01;
  localparam logic [1:0] OP_TLBWR = 2'b11;

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_ENTRIES - 1);

  logic [2:0]       state;
  logic [1:0]       op_q;
  logic [IDX_W-1:0] ptr, idx_q, wr_idx_q;
  logic [31:0]      hi_q, lo0_q, lo1_q;
  logic             accept, match;

  assign accept = op_valid_i & op_ready_o;

  // Global entries ignore ASID; bits 12:8 of EntryHi never take part in the compare.
  assign match = (tlb_rd_entryhi_i[31:13] == hi_q[31:13]) &&
                 ((tlb_rd_entrylo0_i[0] & tlb_rd_entrylo1_i[0]) ||
                  (tlb_rd_entryhi_i[7:0] == hi_q[7:0]));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      op_q       <= '0;
      ptr        <= '0;
      idx_q      <= '0;
      wr_idx_q   <= '0;
      hi_q       <= '0;
      lo0_q      <= '0;
      lo1_q      <= '0;
      index_o    <= '0;
      entryhi_o  <= '0;
      entrylo0_o <= '0;
      entrylo1_o <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          op_q     <= op_i;
          hi_q     <= cp0_entryhi_i;
          lo0_q    <= cp0_entrylo0_i;
          lo1_q    <= cp0_entrylo1_i;
          idx_q    <= cp0_index_i[IDX_W-1:0];
          wr_idx_q <= (op_i == OP_TLBWR) ? random_o : cp0_index_i[IDX_W-1:0];
          ptr      <= '0;
          state    <= (op_i == OP_TLBP) ? S_PROBE :
                      (op_i == OP_TLBR) ? S_READ  : S_WRITE;
        end
        S_PROBE: begin
          if (match) begin
            index_o <= 32'(ptr);
            state   <= S_DONE;
          end else if (ptr == IDX_MAX) begin
            index_o <= 32'h8000_0000;
            state   <= S_DONE;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        S_READ: begin
          entryhi_o  <= {tlb_rd_entryhi_i[31:13], 5'b0, tlb_rd_entryhi_i[7:0]};
          entrylo0_o <= tlb_rd_entrylo0_i;
          entrylo1_o <= tlb_rd_entrylo1_i;
          state      <= S_DONE;
        end
        S_WRITE: state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Random counts down from the top to Wired, then reloads; a Wired write reloads too.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                         random_o <= IDX_MAX;
    else if (cp0_wired_wr_i)           random_o <= IDX_MAX;
    else if (random_o <= cp0_wired_i)  random_o <= IDX_MAX;
    else                               random_o <= random_o - 1'b1;
  end

  assign op_ready_o     = (state == S_IDLE);
  assign done_o         = (state == S_DONE);
  assign index_wr_o     = (state == S_DONE) && (op_q == OP_TLBP);
  assign entry_wr_o     = (state == S_DONE) && (op_q == OP_TLBR);
  assign tlb_wr_o       = (state == S_WRITE);
  assign tlb_index_o    = wr_idx_q;
  assign tlb_entryhi_o  = hi_q;
  assign tlb_entrylo0_o = lo0_q;
  assign tlb_entrylo1_o = lo1_q;
  assign tlb_rd_index_o = (state == S_PROBE) ? ptr : idx_q;

  logic unused_bits;
  assign unused_bits = ^{cp0_index_i[31:IDX_W], tlb_rd_entryhi_i[12:8]};
endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Bench for tlb_op_ctrl: directed vector table, hand sequences for Random/reset/busy,
// and randomized operations checked against an array-level TLB reference model.
module tb_tlb_op_ctrl;
  localparam int N  = 16;
  localparam int IW = 4;

  logic          clk = 1'b0, rst = 1'b1;
  logic          op_valid_i = 1'b0;
  logic [1:0]    op_i = '0;
  logic          op_ready_o, done_o;
  logic [31:0]   cp0_entryhi_i = '0, cp0_entrylo0_i = '0, cp0_entrylo1_i = '0, cp0_index_i = '0;
  logic [IW-1:0] cp0_wired_i = 4'd4;
  logic          cp0_wired_wr_i = 1'b0;
  logic [IW-1:0] random_o;
  logic          index_wr_o, entry_wr_o, tlb_wr_o;
  logic [31:0]   index_o, entryhi_o, entrylo0_o, entrylo1_o;
  logic [IW-1:0] tlb_index_o, tlb_rd_index_o;
  logic [31:0]   tlb_entryhi_o, tlb_entrylo0_o, tlb_entrylo1_o;
  logic [31:0]   tlb_rd_entryhi_i, tlb_rd_entrylo0_i, tlb_rd_entrylo1_i;

  int n_chk = 0, n_err = 0;

  tlb_op_ctrl #(.NUM_ENTRIES(N), .IDX_W(IW)) dut (
    .clk_i(clk), .rst_i(rst), .op_valid_i(op_valid_i), .op_i(op_i),
    .op_ready_o(op_ready_o), .done_o(done_o),
    .cp0_entryhi_i(cp0_entryhi_i), .cp0_entrylo0_i(cp0_entrylo0_i),
    .cp0_entrylo1_i(cp0_entrylo1_i), .cp0_index_i(cp0_index_i),
    .cp0_wired_i(cp0_wired_i), .cp0_wired_wr_i(cp0_wired_wr_i), .random_o(random_o),
    .index_wr_o(index_wr_o), .index_o(index_o), .entry_wr_o(entry_wr_o),
    .entryhi_o(entryhi_o), .entrylo0_o(entrylo0_o), .entrylo1_o(entrylo1_o),
    .tlb_wr_o(tlb_wr_o), .tlb_index_o(tlb_index_o), .tlb_entryhi_o(tlb_entryhi_o),
    .tlb_entrylo0_o(tlb_entrylo0_o), .tlb_entrylo1_o(tlb_entrylo1_o),
    .tlb_rd_index_o(tlb_rd_index_o), .tlb_rd_entryhi_i(tlb_rd_entryhi_i),
    .tlb_rd_entrylo0_i(tlb_rd_entrylo0_i), .tlb_rd_entrylo1_i(tlb_rd_entrylo1_i)
  );

  always #5 clk = ~clk;

  // TLB array driven by the DUT's ports, plus the reference copy updated per operation.
  logic [31:0] env_hi[N], env_lo0[N], env_lo1[N];
  logic [31:0] rf_hi[N], rf_lo0[N], rf_lo1[N];
  assign tlb_rd_entryhi_i  = env_hi[tlb_rd_index_o];
  assign tlb_rd_entrylo0_i = env_lo0[tlb_rd_index_o];
  assign tlb_rd_entrylo1_i = env_lo1[tlb_rd_index_o];
  always @(posedge clk) if (tlb_wr_o) begin
    env_hi[tlb_index_o]  <= tlb_entryhi_o;
    env_lo0[tlb_index_o] <= tlb_entrylo0_o;
    env_lo1[tlb_index_o] <= tlb_entrylo1_o;
  end

  int mdl_rand;
  always @(posedge clk or posedge rst) begin
    if (rst) mdl_rand <= N - 1;
    else if (cp0_wired_wr_i || mdl_rand <= int'(cp0_wired_i)) mdl_rand <= N - 1;
    else mdl_rand <= mdl_rand - 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int search(input logic [31:0] hi);
    for (int k = 0; k < N; k++)
      if (rf_hi[k][31:13] == hi[31:13] &&
          ((rf_lo0[k][0] && rf_lo1[k][0]) || rf_hi[k][7:0] == hi[7:0])) return k;
    return -1;
  endfunction

  // Called just after a negedge with the DUT idle; returns after the done_o cycle.
  task automatic run_op(input logic [1:0] op, input logic [31:0] hi, lo0, lo1, idx,
                        input bit hold, input bit wwr, output int dcyc, output logic [31:0] val);
    int wrn, wrc, k;
    logic [IW-1:0] exp_widx;
    chk("ready_idle", 32'(op_ready_o), 32'd1);
    exp_widx = (op == 2'b11) ? IW'(mdl_rand) : idx[IW-1:0];
    op_i = op; cp0_entryhi_i = hi; cp0_entrylo0_i = lo0; cp0_entrylo1_i = lo1;
    cp0_index_i = idx; cp0_wired_wr_i = wwr; op_valid_i = 1'b1;
    dcyc = -1; wrn = 0; wrc = -1; val = '0;
    for (int c = 1; c <= 40 && dcyc < 0; c++) begin
      @(negedge clk);
      cp0_wired_wr_i = 1'b0; op_valid_i = hold; op_i = 2'b10;
      cp0_entryhi_i = $urandom; cp0_entrylo0_i = $urandom;
      cp0_entrylo1_i = $urandom; cp0_index_i = $urandom;
      chk("random", 32'(random_o), 32'(mdl_rand));
      if (tlb_wr_o) begin
        wrn++; wrc = c; val = 32'(tlb_index_o);
        chk("tlb_index", 32'(tlb_index_o), 32'(exp_widx));
        chk("tlb_hi", tlb_entryhi_o, hi);
        chk("tlb_lo0", tlb_entrylo0_o, lo0);
        chk("tlb_lo1", tlb_entrylo1_o, lo1);
      end
      if (done_o) begin
        dcyc = c; op_valid_i = 1'b0;
        chk("index_wr", 32'(index_wr_o), 32'(op == 2'b00));
        chk("entry_wr", 32'(entry_wr_o), 32'(op == 2'b01));
      end
    end
    op_valid_i = 1'b0;
    if (dcyc < 0) begin
      n_chk++; n_err++;
      $display("FAIL done_timeout: got no done_o expected done_o within 40 cycles");
      return;
    end
    case (op)
      2'b00: begin
        k = search(hi);
        chk("probe_cyc", 32'(dcyc), (k >= 0) ? 32'(k + 2) : 32'(N + 1));
        chk("probe_idx", index_o, (k >= 0) ? 32'(k) : 32'h8000_0000);
        chk("probe_nowr", 32'(wrn), 32'd0);
        val = index_o;
      end
      2'b01: begin
        k = int'(idx[IW-1:0]);
        chk("read_cyc", 32'(dcyc), 32'd2);
        chk("read_hi", entryhi_o, rf_hi[k] & 32'hFFFF_E0FF);
        chk("read_lo0", entrylo0_o, rf_lo0[k]);
        chk("read_lo1", entrylo1_o, rf_lo1[k]);
        val = entrylo0_o;
      end
      default: begin
        chk("write_cyc", 32'(dcyc), 32'd2);
        chk("write_cnt", 32'(wrn), 32'd1);
        chk("write_when", 32'(wrc), 32'd1);
        rf_hi[exp_widx] = hi; rf_lo0[exp_widx] = lo0; rf_lo1[exp_widx] = lo1;
      end
    endcase
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] hi, lo0, lo1, idx;
    int          cyc;
    logic [31:0] val;
  } vec_t;
  vec_t tbl[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int dcyc;
    logic [31:0] val;
    for (int i = 0; i < N; i++) begin
      env_hi[i] = '0; env_lo0[i] = '0; env_lo1[i] = '0;
      rf_hi[i] = '0;  rf_lo0[i] = '0;  rf_lo1[i] = '0;
    end
    tbl[0] = '{2'b10, 32'h2468_A007, 32'h0000_0100, 32'h0000_0200, 32'hFFFF_FFF5, 2, 32'd5};
    tbl[1] = '{2'b00, 32'h2468_A007, 32'h0, 32'h0, 32'h0, 7, 32'h0000_0005};
    tbl[2] = '{2'b00, 32'h2468_A008, 32'h0, 32'h0, 32'h0, 17, 32'h8000_0000};
    tbl[3] = '{2'b10, 32'h2468_A007, 32'h0000_0101, 32'h0000_0201, 32'h5, 2, 32'd5};
    tbl[4] = '{2'b00, 32'h2468_A008, 32'h0, 32'h0, 32'h0, 7, 32'h0000_0005};
    tbl[5] = '{2'b10, 32'h0157_8001, 32'h0000_0040, 32'h0000_0080, 32'h3, 2, 32'd3};
    tbl[6] = '{2'b10, 32'h0157_8001, 32'h0000_00C0, 32'h0000_0180, 32'h9, 2, 32'd9};
    tbl[7] = '{2'b00, 32'h0157_8001, 32'h0, 32'h0, 32'h0, 5, 32'h0000_0003};
    tbl[8] = '{2'b10, 32'h0000_5F03, 32'h0000_1047, 32'h0000_2047, 32'hA, 2, 32'd10};
    tbl[9] = '{2'b01, 32'h0, 32'h0, 32'h0, 32'hA, 2, 32'h0000_1047};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(op_ready_o), 32'd1);
    chk("rst_random", 32'(random_o), 32'(N - 1));
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_tlb_wr", 32'(tlb_wr_o), 32'd0);
    chk("rst_index", index_o, 32'd0);
    chk("rst_entryhi", entryhi_o, 32'd0);
    chk("rst_tlb_index", 32'(tlb_index_o), 32'd0);
    chk("rst_strobes", 32'({index_wr_o, entry_wr_o}), 32'd0);
    rst = 1'b0;

    // Random walk with Wired=4: 15 down to 4, then wrap to 15
    for (int i = 0; i < 13; i++) begin
      chk("rand_seq", 32'(random_o), (i < 12) ? 32'(15 - i) : 32'd15);
      @(negedge clk);
    end
    cp0_wired_wr_i = 1'b1;
    @(negedge clk);
    cp0_wired_wr_i = 1'b0;
    chk("wired_wr_reload", 32'(random_o), 32'd15);
    repeat (6) @(negedge clk);
    chk("rand_at_9", 32'(random_o), 32'd9);
    run_op(2'b11, 32'h1111_2000, 32'h3, 32'h5, 32'h2, 1'b0, 1'b0, dcyc, val);
    chk("tlbwr_index", val, 32'd9);

    foreach (tbl[i]) begin
      @(negedge clk);
      run_op(tbl[i].op, tbl[i].hi, tbl[i].lo0, tbl[i].lo1, tbl[i].idx, 1'b0, 1'b0, dcyc, val);
      chk($sformatf("tbl%0d_cyc", i), 32'(dcyc), 32'(tbl[i].cyc));
      chk($sformatf("tbl%0d_val", i), val, tbl[i].val);
    end

    // A request held high through a probe must not be picked up mid-operation
    @(negedge clk);
    run_op(2'b00, 32'h0157_8001, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, dcyc, val);
    @(negedge clk);
    chk("busy_ignored_wr", 32'(tlb_wr_o), 32'd0);
    chk("busy_ignored_ready", 32'(op_ready_o), 32'd1);

    // Reset in the WRITE cycle aborts without touching the array
    op_i = 2'b10; cp0_index_i = 32'h7; cp0_entryhi_i = 32'h0ABC_D000;
    cp0_entrylo0_i = 32'h77; cp0_entrylo1_i = 32'h99; op_valid_i = 1'b1;
    @(negedge clk);
    op_valid_i = 1'b0;
    chk("pre_rst_wr", 32'(tlb_wr_o), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_wr", 32'(tlb_wr_o), 32'd0);
    chk("rst_async_ready", 32'(op_ready_o), 32'd1);
    chk("rst_async_done", 32'(done_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_no_done", 32'(done_o), 32'd0);
      @(negedge clk);
    end
    chk("rst_no_write", env_hi[7], rf_hi[7]);

    for (int it = 0; it < 40; it++) begin
      logic [1:0]  op;
      logic [31:0] hi;
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) cp0_wired_i = IW'($urandom_range(0, N - 1));
      op = 2'($urandom);
      hi = {19'($urandom_range(0, 3)), 5'($urandom), 8'($urandom_range(0, 1))};
      run_op(op, hi, $urandom, $urandom, $urandom, 1'b0, ($urandom_range(0, 3) == 0),
             dcyc, val);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
